mem_ctrl_mc: RTL
================

Name: mem_ctrl_mc

Overview:
- Parametrised successor to the two-port memory controller: serves NUM_CH requester channels (instruction fetch, vector load/store, future scalar LS) against one byte-wide synchronous RAM port.
- Variable-length byte bursts up to MAX_BYTES per request.
- Round-robin arbitration; little-endian assembly of read data.
- Sits between the requesters and the RAM in the vpu top level.

Parameters:
NUM_CH, 3, number of requester channels (>=1)
ADDR_W, 32, address width (XLEN)
DATA_W, 8, RAM data width in bits (RAM_DATA_WID)
MAX_BYTES, 16, maximum burst length in bytes (VLEN/8)
LEN_W, 32, width of each length field

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
ch_valid  in  NUM_CH  per-channel request; held high until done
ch_we  in  NUM_CH  1 = write, 0 = read
ch_addr  in  NUM_CH*ADDR_W  base byte address, channel k at slice k
ch_len  in  NUM_CH*LEN_W  byte count
ch_src  in  NUM_CH*MAX_BYTES*DATA_W  write data, byte 0 in LSBs
ch_done  out  NUM_CH  one-cycle completion pulse, one-hot
ch_data  out  MAX_BYTES*DATA_W  read data of the last completed read, shared by all channels
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_src  out  DATA_W  RAM write byte
mem_data  in  DATA_W  RAM read byte, valid one cycle after its address

Behaviour:
- Reset (rst==0 at a clock edge):
  - State = IDLE; ch_done = 0; ch_data = 0; mem_addr = 0; mem_we = 0; mem_src = 0.
  - Round-robin pointer = channel 0.
  - Takes effect mid-burst: remaining bytes are dropped and no done is produced. Writes already issued stay in RAM.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Channel selection: among the channels with valid high, pick the first at or after the pointer, wrapping modulo NUM_CH.
  - At that edge, latch the granted channel, we, addr, src and eff_len = min(len, MAX_BYTES). Pointer moves to grant+1 mod NUM_CH.
  - eff_len==0 goes straight to DONE with ch_data unchanged. Otherwise go to RUN with byte index i = 0.
- RUN, one byte per cycle:
  - mem_addr = base+i, with ADDR_W wrap-around.
  - mem_we = latched we.
  - mem_src = src byte i.
  - On the last byte (i == eff_len-1): reads go to DRAIN, writes go to DONE.
- Read capture: mem_data sampled in the cycle after its address is placed in assembly byte i. Bytes at or above eff_len are zero.
- DRAIN: captures the final byte. mem_we = 0. Then DONE.
- DONE, one cycle:
  - ch_done[grant] = 1.
  - For reads, ch_data = assembled value, held until the next read DONE.
  - No grant in this cycle, so the requester has one cycle to drop valid. Then IDLE.
- mem_we = 0 in every state except RUN for a write.
- Latency, request sampled in IDLE at cycle T, length L>0:
  - Read: done in cycle T+L+2.
  - Write: done in cycle T+L+1.
  - L==0: done in cycle T+1.
- Abort: if ch_valid[grant] falls in RUN or DRAIN, the burst stops and the state goes to IDLE with no done.
- Request fields are sampled only at grant; later changes are ignored.

Decomposition:
- Shared package/macros header holds RAM_DATA_WID, XLEN, VLEN, and the state encoding for mem_ctrl_mc.
- One sub-module, rr_arbiter (NUM_CH parameter): request vector, pointer, and update strobe in; one-hot grant plus index out.
- Byte sequencing and assembly stay in mem_ctrl_mc.

Test Plan:
- Reset held 3 cycles mid-write burst -> all outputs 0 and no done. RAM holds only the bytes issued before reset. The next request is granted normally.
- ch1 read, addr 0x100, len 4, RAM[0x100..0x103] = 11 22 33 44 -> mem_addr 0x100..0x103 in consecutive cycles. ch_done[1] at T+6. ch_data = 0x44332211, upper bytes 0.
- ch2 write, len 16, src bytes 0x00..0x0F at 0x200, then ch2 read back 16 bytes -> 16 consecutive writes with mem_we high. Write done at T+17. Readback ch_data = 0x0F0E..0100.
- All three channels request len 1 simultaneously after reset -> grants in order 0,1,2. After ch0 re-requests, the order continues 0 after 2. No channel is granted twice while another is waiting.
- len 0 on ch0 -> done at T+1, no RAM access. len 40 on ch1 -> clamped to 16 bytes, done at T+18.
- ch0 read, len 8; ch_valid[0] dropped after 3 addresses -> no ch_done, return to IDLE, ch_data unchanged. A pending ch1 request is granted next.

Source files
------------

// File: rtl/mem_ctrl_mc_pkg.sv
// Shared constants and state encoding for the multi-channel byte-serial memory controller.
package mem_ctrl_mc_pkg;

  localparam int RAM_DATA_WID = 8;
  localparam int XLEN         = 32;
  localparam int VLEN         = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mc_state_e;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_mc_rr_arbiter.sv
// Rotating-priority arbiter: picks the first requester at or after the pointer.
module rr_arbiter
  import mem_ctrl_mc_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  input  logic              upd_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              hit_o
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Walk the channels starting at the pointer, wrapping modulo NUM_CH.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum_s >= (IDX_W+1)'(NUM_CH)) begin
        sum_s = sum_s - (IDX_W+1)'(NUM_CH);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDX_W-1:0];
      if (upd_i && !found_s && req_i[cand_s]) begin
        found_s       = 1'b1;
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    hit_o = found_s;
  end

endmodule

// File: rtl/mem_ctrl_mc.sv
// Multi-channel controller serialising byte bursts onto one synchronous RAM port.
module mem_ctrl_mc
  import mem_ctrl_mc_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int ADDR_W    = XLEN,
  parameter int DATA_W    = RAM_DATA_WID,
  parameter int MAX_BYTES = VLEN / 8,
  parameter int LEN_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH-1:0]              ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]       ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]        ch_len,
  input  logic [NUM_CH*MAX_BYTES*DATA_W-1:0] ch_src,
  output logic [NUM_CH-1:0]              ch_done,
  output logic [MAX_BYTES*DATA_W-1:0]    ch_data,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_we,
  output logic [DATA_W-1:0]              mem_src,
  input  logic [DATA_W-1:0]              mem_data
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam int BI_W  = $clog2(MAX_BYTES + 1);
  localparam int BUF_W = MAX_BYTES * DATA_W;

  mc_state_e         state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [BUF_W-1:0]  src_q, src_d;
  logic [BI_W-1:0]   len_q, len_d;
  logic [BI_W-1:0]   idx_q, idx_d;
  logic [BUF_W-1:0]  asm_q, asm_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [BUF_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_src_q, mem_src_d;

  logic [NUM_CH-1:0] arb_gnt_s;
  logic [IDX_W-1:0]  arb_idx_s;
  logic              arb_hit_s;

  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [LEN_W-1:0]  sel_len_s;
  logic [BUF_W-1:0]  sel_src_s;
  logic [BI_W-1:0]   eff_len_s;
  logic              cur_valid_s;
  logic [NUM_CH-1:0] cur_onehot_s;
  logic              cap_en_s;
  logic [BI_W-1:0]   cap_idx_s;
  logic              load_data_s;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i (ch_valid),
    .ptr_i (ptr_q),
    .upd_i (state_q == ST_IDLE),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .hit_o (arb_hit_s)
  );

  // Route the candidate channel's request fields and the active channel's valid.
  always_comb begin
    sel_we_s     = 1'b0;
    sel_addr_s   = '0;
    sel_len_s    = '0;
    sel_src_s    = '0;
    cur_valid_s  = 1'b0;
    cur_onehot_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (arb_idx_s == IDX_W'(k)) begin
        sel_we_s   = ch_we[k];
        sel_addr_s = ch_addr[k*ADDR_W +: ADDR_W];
        sel_len_s  = ch_len[k*LEN_W +: LEN_W];
        sel_src_s  = ch_src[k*BUF_W +: BUF_W];
      end else begin
        sel_we_s = sel_we_s;
      end
      if (gnt_q == IDX_W'(k)) begin
        cur_valid_s     = ch_valid[k];
        cur_onehot_s[k] = 1'b1;
      end else begin
        cur_valid_s = cur_valid_s;
      end
    end
    if (sel_len_s > LEN_W'(MAX_BYTES)) begin
      eff_len_s = BI_W'(MAX_BYTES);
    end else begin
      eff_len_s = sel_len_s[BI_W-1:0];
    end
  end

  // Next-state logic: grant, byte sequencing, read capture and completion.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    src_d       = src_q;
    len_d       = len_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    ptr_d       = ptr_q;
    done_d      = '0;
    data_d      = data_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_src_d   = mem_src_q;
    cap_en_s    = 1'b0;
    cap_idx_s   = '0;
    load_data_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_hit_s) begin
          gnt_d = arb_idx_s;
          we_d  = sel_we_s;
          len_d = eff_len_s;
          idx_d = '0;
          asm_d = '0;
          if (arb_idx_s == IDX_W'(NUM_CH - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = arb_idx_s + IDX_W'(1);
          end
          if (eff_len_s == '0) begin
            // Empty burst: complete without touching the RAM.
            state_d = ST_DONE;
            done_d  = arb_gnt_s;
          end else begin
            // Present byte 0 on the RAM port in the first RUN cycle.
            state_d    = ST_RUN;
            mem_addr_d = sel_addr_s;
            mem_we_d   = sel_we_s;
            mem_src_d  = sel_src_s[DATA_W-1:0];
            src_d      = sel_src_s >> DATA_W;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (!cur_valid_s) begin
          state_d = ST_IDLE;
        end else begin
          // Data for the previous address arrives this cycle.
          cap_en_s  = (idx_q != '0);
          cap_idx_s = idx_q - BI_W'(1);
          if (idx_q == len_q - BI_W'(1)) begin
            if (we_q) begin
              state_d = ST_DONE;
              done_d  = cur_onehot_s;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            idx_d      = idx_q + BI_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            mem_we_d   = we_q;
            mem_src_d  = src_q[DATA_W-1:0];
            src_d      = src_q >> DATA_W;
          end
        end
      end

      ST_DRAIN: begin
        if (!cur_valid_s) begin
          state_d = ST_IDLE;
        end else begin
          cap_en_s    = 1'b1;
          cap_idx_s   = idx_q;
          load_data_s = 1'b1;
          state_d     = ST_DONE;
          done_d      = cur_onehot_s;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int k = 0; k < MAX_BYTES; k++) begin
      if (cap_en_s && (cap_idx_s == BI_W'(k))) begin
        asm_d[k*DATA_W +: DATA_W] = mem_data;
      end else begin
        asm_d[k*DATA_W +: DATA_W] = asm_d[k*DATA_W +: DATA_W];
      end
    end

    if (load_data_s) begin
      data_d = asm_d;
    end else begin
      data_d = data_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      we_q       <= 1'b0;
      src_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      ptr_q      <= '0;
      done_q     <= '0;
      data_q     <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      src_q      <= src_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      ptr_q      <= ptr_d;
      done_q     <= done_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_src_q  <= mem_src_d;
    end
  end

  assign ch_done  = done_q;
  assign ch_data  = data_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign mem_src  = mem_src_q;

endmodule
